dsa_pixel_store_simd: RTL and testbench
=======================================

// Module: dsa_pixel_store_simd
// PURPOSE
//  Write-back counterpart of the SIMD pixel fetch unit. Accepts SIMD_WIDTH interpolated
//  8-bit output pixels for one horizontal run (dst_x..dst_x+SIMD_WIDTH-1, row dst_y).
//  Writes them one byte per cycle to the output image in pixel memory, clipping lanes past the right edge.
//  One-entry pending buffer lets the interpolator hand over the next vector while the current one drains.
// PARAMETERS
//  ADDR_WIDTH  18  pixel memory byte-address width
//  SIMD_WIDTH  4   pixels per vector (power of 2, 2..8)
// PORTS
//  clk            in   1            system clock, all state on rising edge
//  rst_n          in   1            asynchronous, active-low reset
//  in_valid       in   1            vector offered
//  in_ready       out  1            vector accepted on cycle in_valid && in_ready
//  dst_x          in   16           output x of lane 0
//  dst_y          in   16           output row
//  pix            in   8 x SIMD_WIDTH  lane pixels, pix[i] goes to dst_x+i
//  out_width      in   16           output image width (row stride and clip bound), static while busy
//  img_base_addr  in   ADDR_WIDTH   output image base address, static while busy
//  mem_write_en   out  1            write strobe
//  mem_addr       out  ADDR_WIDTH   write byte address
//  mem_wdata      out  8            write data
//  mem_wait       in   1            stall: write completes only on mem_write_en && !mem_wait
//  cnt_clear      in   1            synchronous clear of pix_count
//  vec_done       out  1            1-cycle pulse, current vector finished (incl. fully clipped)
//  pix_count      out  24           total completed writes since reset/clear, wraps at 2^24
//  busy           out  1            state != ST_IDLE or pending slot full
// BEHAVIOUR
//  Reset values: all outputs 0 except in_ready=1.
//  - Reset clears state to ST_IDLE, empties the pending slot and zeroes pix_count.
//  - Reset mid-write aborts the vector immediately; the in-flight write and the pending vector are dropped.
//  Slots: current (cur) + pending (pend_v). in_ready = !pend_v.
//  - An accepted vector goes to cur if state is ST_IDLE, or ST_DONE with !pend_v.
//  - Otherwise it goes to pend.
//  FSM:
//  - ST_IDLE: accept -> ST_ADDR.
//  - ST_ADDR (1 cycle):
//    - row_base = img_base_addr + dst_y*out_width + dst_x, truncated to ADDR_WIDTH.
//    - lane_mask[i] = (dst_x+i < out_width), compared in 17 bits.
//    - mask==0 -> ST_DONE, else ST_WRITE.
//  - ST_WRITE: lane = lowest set mask bit.
//    - mem_write_en=1, mem_addr=row_base+lane, mem_wdata=pix_r[lane].
//    - On completion, clear that mask bit; last bit -> ST_DONE. Clipped lanes cost 0 cycles.
//    - While mem_wait=1: addr/data/en held stable, no advance.
//  - ST_DONE (1 cycle): vec_done=1.
//    - pend_v -> move pend to cur, pend_v<=0, go ST_ADDR.
//    - Else if accept this cycle -> ST_ADDR; else -> ST_IDLE.
//  Latency: accept at edge T; first write asserted cycle T+2.
//  - Gap between last lane of one vector and lane 0 of the next is exactly 2 cycles (DONE, ADDR).
//  pix_count +1 per completed write; cnt_clear has priority (same-cycle write not counted).
//  No combinational path from any input port to any output port.
//  vec_done/mem_write_en never asserted in the same cycle.
// TESTING
//  1. base=0x100, out_width=64, dst=(8,2), pix={11,22,33,44}, mem_wait=0:
//     - writes 0x188..0x18B with data 11,22,33,44 on 4 consecutive cycles from T+2.
//     - vec_done pulses once at T+6; pix_count=4.
//  2. Same setup, dst_x=62:
//     - only 0x1BE=11 and 0x1BF=22 written; pix_count +2.
//     - dst_x=64 -> no writes, vec_done still pulses at T+2.
//  3. mem_wait high 3 cycles during lane 1:
//     - addr/data held stable; each lane written once; write phase 7 cycles; pix_count=4.
//  4. Three vectors offered back-to-back:
//     - #2 accepted during #1's writes, then in_ready=0 until ST_DONE of #1.
//     - 12 writes in order; 2-cycle gaps between vectors.
//  5. Assert rst_n low after lane 1 of a vector with a pending vector:
//     - outputs reset immediately; pend dropped; pix_count=0.
//     - a new vector after release writes normally.
//  6. cnt_clear coincident with a completing write -> pix_count=0 next cycle; following write -> 1.

Source files
------------

// File: rtl/dsa_pixel_store_simd.sv
// Pixel write-back unit: takes SIMD_WIDTH-lane pixel vectors for one horizontal run
// and writes the in-bounds lanes to pixel memory one byte per cycle. A one-entry
// pending slot lets the producer hand over the next vector while the current drains.
module dsa_pixel_store_simd #(
    parameter int ADDR_WIDTH = 18,   // pixel memory byte-address width (at most 32)
    parameter int SIMD_WIDTH = 4     // pixels per vector, power of 2 in 2..8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [15:0]             i_dst_x,
    input  logic [15:0]             i_dst_y,
    input  logic [8*SIMD_WIDTH-1:0] i_pix,
    input  logic [15:0]             i_out_width,
    input  logic [ADDR_WIDTH-1:0]   i_img_base_addr,
    output logic                    o_mem_write_en,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [7:0]              o_mem_wdata,
    input  logic                    i_mem_wait,
    input  logic                    i_cnt_clear,
    output logic                    o_vec_done,
    output logic [23:0]             o_pix_count,
    output logic                    o_busy
);

    localparam int LANE_W = $clog2(SIMD_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // Current vector being written and the pending vector waiting behind it
    logic [15:0]             r_cur_x;
    logic [15:0]             r_cur_y;
    logic [8*SIMD_WIDTH-1:0] r_cur_pix;
    logic                    r_pend_v;
    logic [15:0]             r_pend_x;
    logic [15:0]             r_pend_y;
    logic [8*SIMD_WIDTH-1:0] r_pend_pix;

    logic [ADDR_WIDTH-1:0]   r_row_base;
    logic [SIMD_WIDTH-1:0]   r_mask;
    logic [23:0]             r_pix_count;

    logic                    w_accept;
    logic                    w_to_cur;
    logic                    w_wr_done;
    logic [SIMD_WIDTH-1:0]   w_lane_in_bounds;
    logic [SIMD_WIDTH-1:0]   w_lane_onehot;
    logic [SIMD_WIDTH-1:0]   w_mask_after;
    logic [LANE_W-1:0]       w_lane;
    logic [31:0]             w_row_base_full;

    assign w_accept  = i_in_valid && !r_pend_v;
    // The current slot is free only when idle, or when the vector is finishing and nothing waits
    assign w_to_cur  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && !r_pend_v);
    assign w_wr_done = (r_state == ST_WRITE) && !i_mem_wait;

    // Lane clip test in 17 bits so dst_x+i cannot wrap past 0xFFFF
    generate
        for (genvar gi = 0; gi < SIMD_WIDTH; gi++) begin : g_bounds
            assign w_lane_in_bounds[gi] = ({1'b0, r_cur_x} + 17'(gi)) < {1'b0, i_out_width};
        end
    endgenerate

    // Address arithmetic done in 32 bits then truncated to the memory width
    assign w_row_base_full = 32'(i_img_base_addr) + (32'(r_cur_y) * 32'(i_out_width)) + 32'(r_cur_x);

    // Isolate the lowest remaining lane; clipped lanes are never in the mask so cost no cycles
    assign w_lane_onehot = r_mask & (~r_mask + 1'b1);
    assign w_mask_after  = r_mask & ~w_lane_onehot;

    // Encode the one-hot lane select into an index
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < SIMD_WIDTH; i++) begin
            if (w_lane_onehot[i]) begin
                w_lane = LANE_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_next = ST_ADDR;
            ST_ADDR:  w_state_next = (w_lane_in_bounds == '0) ? ST_DONE : ST_WRITE;
            ST_WRITE: if (w_wr_done && (w_mask_after == '0)) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = (r_pend_v || w_accept) ? ST_ADDR : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only; address/data forced to 0 when not writing
    always_comb begin
        o_mem_write_en = 1'b0;
        o_mem_addr     = '0;
        o_mem_wdata    = '0;
        o_vec_done     = 1'b0;
        if (r_state == ST_WRITE) begin
            o_mem_write_en = 1'b1;
            o_mem_addr     = r_row_base + ADDR_WIDTH'(w_lane);
            o_mem_wdata    = r_cur_pix[{w_lane, 3'b000} +: 8];
        end
        if (r_state == ST_DONE) begin
            o_vec_done = 1'b1;
        end
    end

    assign o_in_ready  = !r_pend_v;
    assign o_busy      = (r_state != ST_IDLE) || r_pend_v;
    assign o_pix_count = r_pix_count;

    // Slot management: load current directly when free, otherwise park in pending
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_cur_pix  <= '0;
            r_pend_v   <= 1'b0;
            r_pend_x   <= '0;
            r_pend_y   <= '0;
            r_pend_pix <= '0;
        end else begin
            if (w_accept && w_to_cur) begin
                r_cur_x   <= i_dst_x;
                r_cur_y   <= i_dst_y;
                r_cur_pix <= i_pix;
            end else if (w_accept) begin
                r_pend_v   <= 1'b1;
                r_pend_x   <= i_dst_x;
                r_pend_y   <= i_dst_y;
                r_pend_pix <= i_pix;
            end else if ((r_state == ST_DONE) && r_pend_v) begin
                r_cur_x   <= r_pend_x;
                r_cur_y   <= r_pend_y;
                r_cur_pix <= r_pend_pix;
                r_pend_v  <= 1'b0;
            end
        end
    end

    // Row base and lane mask latched in ST_ADDR; mask bits retire as writes complete
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row_base <= '0;
            r_mask     <= '0;
        end else if (r_state == ST_ADDR) begin
            r_row_base <= w_row_base_full[ADDR_WIDTH-1:0];
            r_mask     <= w_lane_in_bounds;
        end else if (w_wr_done) begin
            r_mask     <= w_mask_after;
        end
    end

    // Completed-write counter; clear wins over a same-cycle completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_count <= '0;
        end else if (i_cnt_clear) begin
            r_pix_count <= '0;
        end else if (w_wr_done) begin
            r_pix_count <= r_pix_count + 24'd1;
        end
    end

endmodule

// File: tb/tb_dsa_pixel_store_simd.sv
// Testbench for dsa_pixel_store_simd: expected writes are queued when a vector is
// accepted and checked in order as the DUT completes memory writes.
module tb_dsa_pixel_store_simd;

    localparam int AW = 18;
    localparam int SW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     dst_x;
    logic [15:0]     dst_y;
    logic [8*SW-1:0] pix;
    logic [15:0]     out_width;
    logic [AW-1:0]   img_base_addr;
    logic            mem_write_en;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic            mem_wait;
    logic            cnt_clear;
    logic            vec_done;
    logic [23:0]     pix_count;
    logic            busy;

    dsa_pixel_store_simd #(.ADDR_WIDTH(AW), .SIMD_WIDTH(SW)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_dst_x         (dst_x),
        .i_dst_y         (dst_y),
        .i_pix           (pix),
        .i_out_width     (out_width),
        .i_img_base_addr (img_base_addr),
        .o_mem_write_en  (mem_write_en),
        .o_mem_addr      (mem_addr),
        .o_mem_wdata     (mem_wdata),
        .i_mem_wait      (mem_wait),
        .i_cnt_clear     (cnt_clear),
        .o_vec_done      (vec_done),
        .o_pix_count     (pix_count),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    exp_t exp_q[$];
    int   wr_cyc_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_wr     = 0;
    int   n_vd     = 0;
    int   last_vd  = -1;

    logic          held_v = 1'b0;
    logic [AW-1:0] held_addr;
    logic [7:0]    held_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboard pop on each completed write, hold check while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("hold_en",   32'(mem_write_en), 32'd1);
                chk("hold_addr", 32'(mem_addr),     32'(held_addr));
                chk("hold_data", 32'(mem_wdata),    32'(held_data));
            end
            held_v    = mem_write_en && mem_wait;
            held_addr = mem_addr;
            held_data = mem_wdata;
            if (mem_write_en && !mem_wait) begin
                exp_t e;
                wr_cyc_q.push_back(cyc);
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr),  32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                    $display("write addr=0x%05h data=%0d (cycle %0d)", mem_addr, mem_wdata, cyc);
                end
            end
            if (vec_done) begin
                n_vd++;
                last_vd = cyc;
                chk("vd_excl_we", 32'(mem_write_en), 32'd0);
            end
        end
    end

    // Reference model of the lanes a vector should write
    task automatic push_exp(input logic [15:0] x, input logic [15:0] y, input logic [8*SW-1:0] p);
        exp_t        e;
        logic [63:0] a;
        for (int i = 0; i < SW; i++) begin
            if ((17'(x) + 17'(i)) < 17'(out_width)) begin
                a      = 64'(img_base_addr) + 64'(y) * 64'(out_width) + 64'(x) + 64'(i);
                e.addr = a[AW-1:0];
                e.data = p[8*i +: 8];
                exp_q.push_back(e);
            end
        end
    endtask

    // Offer a vector starting just after a rising edge; returns just after the accept edge
    task automatic send_vec(input logic [15:0] x, input logic [15:0] y, input logic [8*SW-1:0] p,
                            output int acc_cyc);
        bit ok = 0;
        in_valid = 1'b1;
        dst_x    = x;
        dst_y    = y;
        pix      = p;
        acc_cyc  = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_cyc  = cyc;
            push_exp(x, y, p);
            $display("accept x=%0d y=%0d pix=0x%08h (cycle %0d)", x, y, p, cyc);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("idle_reached", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        @(posedge clk);
        #1 cnt_clear = 1'b0;
    endtask

    int a1, a2, a3, nvd0, nwr0, w0;

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        dst_x         = '0;
        dst_y         = '0;
        pix           = '0;
        out_width     = 16'd64;
        img_base_addr = 18'h100;
        mem_wait      = 1'b0;
        cnt_clear     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready),     32'd1);
        chk("rst_we",       32'(mem_write_en), 32'd0);
        chk("rst_addr",     32'(mem_addr),     32'd0);
        chk("rst_wdata",    32'(mem_wdata),    32'd0);
        chk("rst_vd",       32'(vec_done),     32'd0);
        chk("rst_count",    32'(pix_count),    32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full vector, cycle-exact write and done timing
        send_vec(16'd8, 16'd2, {8'd44, 8'd33, 8'd22, 8'd11}, a1);
        chk("t1_first_addr", 32'(exp_q[0].addr), 32'h188);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("t1_we", 32'(mem_write_en), 32'((k >= 2) && (k <= 5)));
            chk("t1_vd", 32'(vec_done),     32'(k == 6));
        end
        wait_idle();
        chk("t1_count", 32'(pix_count), 32'd4);

        // 2: right-edge clip, then a fully clipped vector
        send_vec(16'd62, 16'd2, {8'd44, 8'd33, 8'd22, 8'd11}, a1);
        wait_idle();
        chk("t2_count", 32'(pix_count), 32'd6);
        nvd0 = n_vd;
        nwr0 = n_wr;
        send_vec(16'd64, 16'd2, {8'd4, 8'd3, 8'd2, 8'd1}, a1);
        wait_idle();
        chk("t2_clip_vd_cyc", 32'(last_vd - a1), 32'd1);
        chk("t2_clip_vd_cnt", 32'(n_vd - nvd0),  32'd1);
        chk("t2_clip_nowr",   32'(n_wr - nwr0),  32'd0);
        chk("t2_clip_count",  32'(pix_count),    32'd6);

        // 3: memory stall for 3 cycles on lane 1
        pulse_clear();
        chk("t3_cleared", 32'(pix_count), 32'd0);
        send_vec(16'd8, 16'd2, {8'd55, 8'd66, 8'd77, 8'd88}, a1);
        @(posedge clk); #1;
        @(posedge clk); #1 mem_wait = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_wait = 1'b0;
        wait_idle();
        chk("t3_vd_cyc", 32'(last_vd - a1), 32'd8);
        chk("t3_count",  32'(pix_count),    32'd4);

        // 4: three back-to-back vectors, one with a row address that wraps
        wr_cyc_q.delete();
        send_vec(16'd0,  16'd1,    32'($urandom), a1);
        send_vec(16'd20, 16'd3,    32'($urandom), a2);
        send_vec(16'd4,  16'd4500, 32'($urandom), a3);
        wait_idle();
        chk("t4_acc2", 32'(a2 - a1), 32'd1);
        chk("t4_acc3", 32'(a3 - a1), 32'd7);
        chk("t4_nwr",  32'(wr_cyc_q.size()), 32'd12);
        if (wr_cyc_q.size() == 12) begin
            chk("t4_gap12", 32'(wr_cyc_q[4] - wr_cyc_q[3]), 32'd3);
            chk("t4_gap23", 32'(wr_cyc_q[8] - wr_cyc_q[7]), 32'd3);
        end
        chk("t4_count", 32'(pix_count), 32'd16);

        // 5: asynchronous reset mid-vector with a pending vector
        send_vec(16'd8, 16'd2, {8'd1, 8'd2, 8'd3, 8'd4}, a1);
        send_vec(16'd12, 16'd2, {8'd5, 8'd6, 8'd7, 8'd8}, a2);
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_we",    32'(mem_write_en), 32'd0);
        chk("t5_rst_ready", 32'(in_ready),     32'd1);
        chk("t5_rst_busy",  32'(busy),         32'd0);
        chk("t5_rst_count", 32'(pix_count),    32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send_vec(16'd30, 16'd7, {8'd9, 8'd10, 8'd11, 8'd12}, a1);
        wait_idle();
        chk("t5_count", 32'(pix_count), 32'd4);

        // 6: clear coincident with a completing write
        send_vec(16'd0, 16'd0, {8'd13, 8'd14, 8'd15, 8'd16}, a1);
        @(posedge clk); #1;
        @(posedge clk); #1 cnt_clear = 1'b1;
        @(posedge clk); #1 cnt_clear = 1'b0;
        @(negedge clk);
        chk("t6_cleared", 32'(pix_count), 32'd0);
        @(negedge clk);
        chk("t6_next",    32'(pix_count), 32'd1);
        wait_idle();
        chk("t6_final",   32'(pix_count), 32'd2);
        chk("sb_empty",   32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
